// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch payload carried from fetch to decode.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush empties it in one edge.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty FIFO presents zeros so decode never sees stale storage.
  always_comb begin
    head = '0;
    if (count != '0) begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns pc, issues credit-limited reads, buffers tagged words for decode.
// Optional halt-on-HALT_WORD behaviour is enabled by defining FETCH_HALT_EN.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [DATA_W-1:0] read_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              pending;
  logic              halted_q;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  logic              halt_hit;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Credit: buffered + in-flight - leaving this cycle must stay below capacity.
  always_comb begin
    pop              = instr_valid & instr_ready;
    occupancy        = OCC_W'(count) + OCC_W'(pending) - OCC_W'(pop);
    issue            = !rst && !redirect && !halted_q && (occupancy < OCC_W'(BUF_DEPTH));
    push             = pending && !rst && !redirect && !halted_q;
    push_entry.instr = read_data;
    push_entry.pc    = req_pc;
  end

`ifdef FETCH_HALT_EN
  assign halt_hit = push && (read_data == HALT_WORD);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      req_pc  <= '0;
      pending <= 1'b0;
    end else if (redirect) begin
      pc      <= redirect_pc;
      pending <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pc     <= pc + ADDR_W'(1);
        req_pc <= pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      halted_q <= 1'b0;
    end else if (halt_hit) begin
      halted_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign mem_address = pc;
  assign mem_read    = issue;
  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model plus an in-order expected-pc scoreboard.
module tb_instruction_fetch;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic [DATA_W-1:0] read_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;

  logic [DATA_W-1:0] mem [256];
  logic [ADDR_W-1:0] exp_pc;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  // Program memory with registered read data.
  always @(posedge clk) begin
    if (mem_read) read_data <= mem[mem_address];
  end

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .read_data   (read_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    checks++; if (instr !== '0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if (instr_pc !== '0) begin errors++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (mem_address !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", mem_address); end
    exp_pc = 8'h00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      if (c == 0) begin
        checks++; if (mem_read !== 1'b1 || mem_address !== 8'h00) begin errors++; $display("FAIL first_issue got rd=%b addr=%h want 1/00", mem_read, mem_address); end
      end
      checks++; if (instr_valid !== (c >= 2)) begin errors++; $display("FAIL startup_valid c=%0d got %b want %b", c, instr_valid, c >= 2); end
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_reset got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]); end
        exp_pc++;
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      instr_ready = !(c >= 2 && c < 7);
      #1;
      if (c >= 2 && c < 7) begin
        checks++; if (mem_read !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall c=%0d got rd=%b valid=%b want 0/1", c, mem_read, instr_valid); end
      end
      if (c >= 7) begin
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL drain_valid c=%0d got %b want 1", c, instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_stall got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]); end
        exp_pc++;
      end
    end
  endtask

  task automatic test_redirect();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); #1;
      instr_ready = (c != 1);
      redirect    = (c == 1);
      redirect_pc = 8'h40;
      #1;
      if (c == 1) begin
        checks++; if (instr_valid !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL redir_setup got valid=%b rd=%b want 1/0", instr_valid, mem_read); end
      end
      if (c == 2) begin
        checks++; if (mem_address !== 8'h40 || mem_read !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_n1 got addr=%h rd=%b valid=%b want 40/1/0", mem_address, mem_read, instr_valid); end
      end
      if (c == 3) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_n2 got valid=%b want 0", instr_valid); end
      end
      if (c == 4) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40) begin errors++; $display("FAIL redir_n3 got valid=%b pc=%h want 1/40", instr_valid, instr_pc); end
      end
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_redirect got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]); end
        exp_pc++;
      end
      if (redirect) exp_pc = redirect_pc;
    end
    redirect = 1'b0;
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] want [4];
    logic [ADDR_W-1:0] seen [$];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      instr_ready = 1'b1;
      redirect    = (c == 0);
      redirect_pc = 8'hFE;
      #1;
      if (instr_valid && instr_ready) begin
        if (!redirect) seen.push_back(instr_pc);
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_wrap got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]); end
        exp_pc++;
      end
      if (redirect) exp_pc = redirect_pc;
    end
    redirect = 1'b0;
    checks++; if (seen.size() < 4) begin errors++; $display("FAIL wrap_count got %0d want >=4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== want[i]) begin errors++; $display("FAIL wrap_seq[%0d] got %h want %h", i, seen[i], want[i]); end
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    bit saw_halt = 1'b0;
    mem[5] = HALT_WORD;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      instr_ready = 1'b1;
      redirect    = (c == 0);
      redirect_pc = 8'h03;
      #1;
      if (c >= 6) begin
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL halt_no_issue c=%0d got rd=%b want 0", c, mem_read); end
      end
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_halt got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]); end
        if (instr === HALT_WORD) saw_halt = 1'b1;
        exp_pc++;
      end
      if (redirect) exp_pc = redirect_pc;
    end
    redirect = 1'b0;
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || !saw_halt || exp_pc !== 8'h06) begin errors++; $display("FAIL halt_state got halted=%b valid=%b saw=%b next=%h want 1/0/1/06", halted, instr_valid, saw_halt, exp_pc); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      redirect    = (c == 0);
      redirect_pc = 8'h10;
      #1;
      if (c == 1) begin
        checks++; if (halted !== 1'b0 || mem_read !== 1'b1 || mem_address !== 8'h10) begin errors++; $display("FAIL halt_resume got halted=%b rd=%b addr=%h want 0/1/10", halted, mem_read, mem_address); end
      end
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_resume got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]); end
        exp_pc++;
      end
      if (redirect) exp_pc = redirect_pc;
    end
    redirect = 1'b0;
    checks++; if (exp_pc === 8'h10) begin errors++; $display("FAIL resume_progress got next=%h want >10", exp_pc); end
    mem[5] = 32'd105;
  endtask
`endif

  task automatic test_midreset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); #1;
      instr_ready = 1'b1;
      rst         = (c == 2);
      #1;
      if (c == 3) begin
        checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 8'h00) begin errors++; $display("FAIL midreset got valid=%b rd=%b addr=%h want 0/1/00", instr_valid, mem_read, mem_address); end
      end
      if (c == 5) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin errors++; $display("FAIL midreset_restart got valid=%b pc=%h want 1/00", instr_valid, instr_pc); end
      end
      if (!rst && instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_midreset got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]); end
        exp_pc++;
      end
      if (rst) exp_pc = 8'h00;
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit prev_redirect = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0) || c == 100 || c == 101;
      redirect_pc = ADDR_W'($urandom);
      #1;
      if (prev_redirect) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush c=%0d got valid=%b want 0", c, instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin errors++; $display("FAIL pop_random c=%0d got pc=%h instr=%h want pc=%h instr=%h", c, instr_pc, instr, exp_pc, mem[exp_pc]); end
        exp_pc++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_redirect = redirect;
    end
    redirect = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0; read_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'(i + 100);
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
